seq_recognizer: RTL and testbench
=================================

# seq_recognizer

Parametrised Mealy sequence recognizer: the generalisation of the fixed "abba" string automata. Symbol width, pattern length and overlap mode are parameters, and the pattern is loaded at run time. It watches a qualified stream of W-bit symbols and asserts `z` in the same cycle as the symbol that completes the programmed pattern. It also keeps a saturating match count. It sits in the automata library as the drop-in replacement for hand-derived sigma/omega recognizers.

## Interface
- `W`, 2: symbol width in bits (≥1).
- `L`, 4: pattern length in symbols (≥2).
- `OVERLAP`, 1: 1 = overlapping matches counted; 0 = history discarded after each match.
- `CW`, 8: match counter width.

- `clock`  in  1  sole clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high; highest priority.
- `load`  in  1  capture `pattern` on this edge.
- `pattern`  in  W*L  symbol k at bits [k*W +: W]; symbol 0 is the first expected.
- `valid`  in  1  `x` carries a symbol this cycle.
- `x`  in  W  input symbol.
- `z`  out  1  match (combinational, Mealy).
- `count`  out  CW  matches since last load/reset, saturating.
- `armed`  out  1  a pattern is loaded (state RUN).

## Operation
- Internal state:
  - FSM {IDLE, RUN}
  - pattern register `pat` (W*L)
  - history shift register `hist` of L-1 symbols; `hist[L-2]` is the most recent
  - fill counter `fill`, 0..L-1
  - `count`
- Reset (edge with `reset`=1): FSM=IDLE, `pat`=0, `hist`=0, `fill`=0, `count`=0. Outputs after reset: `z`=0, `count`=0, `armed`=0.
- IDLE:
  - `z`=0; `valid`/`x` ignored.
  - `load`=1 → capture `pattern`, `fill`=0, `count`=0, go RUN.
- RUN:
  - `z` = `valid` & (`fill`==L-1) & (`hist[i]`==`pat[i]` for i=0..L-2) & (`x`==`pat[L-1]`).
  - Edge with `valid`=1, `load`=0:
    - shift `x` into `hist` (oldest dropped).
    - `fill` = min(`fill`+1, L-1).
  - If `z`=1 on that edge:
    - `count` += 1, saturating at 2^CW-1.
    - If OVERLAP=0, `fill` is forced to 0; this overrides the increment, and the completing symbol is not retained for a future match.
  - `valid`=0: no state change, `z`=0.
  - `load`=1: recapture `pattern`, `fill`=0, `count`=0, stay RUN. The symbol presented that cycle is discarded and not counted, even if `z`=1 combinationally.
- Priority: `reset` > `load` > `valid`.
- `hist` contents with `fill`<L-1 are don't-care; the `fill` gating prevents false matches from stale or zero history after load.
- `armed` = (FSM==RUN), registered.

## Timing
- `z`: pure combinational from `valid`, `x` and registered state; valid in the same cycle as the completing symbol, zero latency.
- `count`, `armed`: change only at posedge.
  - `count` reflects a match one cycle after the `z` cycle.
  - `armed` rises the cycle after the `load` edge.
- First possible match: L-th valid symbol after load (L symbols minimum, any number of `valid`=0 gaps allowed in between).
- Reset mid-stream: the next cycle is IDLE with all outputs 0; the pattern must be reloaded.
- Counter saturation: `count` holds 2^CW-1; `z` keeps asserting normally.

## Test plan
- Reset, then `valid`=1 with arbitrary symbols and no load → `z`=0 every cycle, `armed`=0, `count`=0.
- W=2, L=4, OVERLAP=1, pattern a,b,b,a (a=01, b=10); stream a b b a b b a → `z`=1 on symbols 4 and 7 only; `count`=2.
- Same stream, OVERLAP=0 → `z`=1 on symbol 4 only; `count`=1.
- Pattern a,a,a,a, stream of six a's:
  - OVERLAP=1 → `z` on symbols 4, 5, 6 (`count`=3).
  - OVERLAP=0 → `z` on symbol 4 only (`count`=1).
- Pattern abba with `valid`=0 gaps between every symbol → still one `z` on the 4th valid symbol.
  - `load` asserted together with that 4th symbol → symbol discarded, `count`=0.
  - `reset` asserted mid-pattern → IDLE, `armed`=0.
- CW=2, OVERLAP=1, pattern aaaa, stream of 8 a's → `z` on symbols 4-8; `count` reads 1, 2, 3, then holds 3.

Source files
------------

// File: rtl/seq_recognizer.sv
// ---------------------------------------------------------------------------
// seq_recognizer
//
// Parametrised Mealy sequence recognizer. It watches a qualified stream of
// W-bit symbols. It raises z in the same cycle as the symbol that completes
// the run-time programmed pattern of L symbols. It also keeps a saturating
// count of matches since the last load or reset.
//
// Parameters
//   W        symbol width in bits (>= 1)
//   L        pattern length in symbols (>= 2)
//   OVERLAP  1 = overlapping matches are counted,
//            0 = history is discarded after every match
//   CW       match counter width
//
// Ports
//   clock    in   1      sole clock, all state changes on posedge
//   reset    in   1      synchronous, active-high, highest priority
//   load     in   1      capture pattern on this edge (restarts matching)
//   pattern  in   W*L    symbol k at [k*W +: W], symbol 0 expected first
//   valid    in   1      x carries a symbol this cycle
//   x        in   W      input symbol
//   z        out  1      match, combinational (Mealy)
//   count    out  CW     matches since last load/reset, saturating
//   armed    out  1      a pattern is loaded (FSM in RUN)
// ---------------------------------------------------------------------------
module seq_recognizer #(
    parameter int W       = 2,
    parameter int L       = 4,
    parameter int OVERLAP = 1,
    parameter int CW      = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic [W*L-1:0] pattern,
    input  logic           valid,
    input  logic [W-1:0]   x,
    output logic           z,
    output logic [CW-1:0]  count,
    output logic           armed
);

    localparam int HW = (L - 1) * W;
    localparam int FW = $clog2(L);
    localparam logic [FW-1:0] FILL_MAX  = FW'(L - 1);
    localparam logic [CW-1:0] COUNT_MAX = '1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t         state;
    logic [W*L-1:0] pat;
    logic [HW-1:0]  hist;
    logic [FW-1:0]  fill;
    logic [HW-1:0]  hist_next;
    logic [FW-1:0]  fill_inc;
    logic           hist_match;
    logic           last_match;

    // History slot i sits at hist[i*W +: W]. This is the same layout as
    // pattern symbol i, so the whole history compares against the low
    // L-1 pattern symbols in one step. The newest symbol enters at the top
    // slot (L-2), and the oldest symbol falls off the bottom.
    generate
        if (L == 2) begin : g_hist_single
            assign hist_next = x;
        end else begin : g_hist_shift
            assign hist_next = {x, hist[HW-1:W]};
        end
    endgenerate

    assign hist_match = (hist == pat[HW-1:0]);
    assign last_match = (x == pat[HW +: W]);

    // The fill counter saturates at L-1. It gates the match so that stale
    // or reset history left over from before a load can never fire.
    assign fill_inc = (fill == FILL_MAX) ? FILL_MAX : fill + 1'b1;

    // The match output is Mealy. It depends on the live valid and x inputs
    // as well as the registered state, so it shows in the completing cycle.
    assign z = (state == RUN) && valid && (fill == FILL_MAX) && hist_match && last_match;

    assign armed = (state == RUN);

    // Control and datapath state. Reset has the highest priority, then load,
    // then valid. A load in RUN drops the symbol presented in that cycle,
    // even when z is high on that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pat   <= '0;
            hist  <= '0;
            fill  <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        pat   <= pattern;
                        fill  <= '0;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        pat   <= pattern;
                        fill  <= '0;
                        count <= '0;
                    end else if (valid) begin
                        hist <= hist_next;
                        if (z) begin
                            if (count != COUNT_MAX) begin
                                count <= count + 1'b1;
                            end
                            // In non-overlapping mode the completing symbol
                            // must not seed the next match. Restarting the
                            // fill gives the next match a clean start.
                            if (OVERLAP == 0) begin
                                fill <= '0;
                            end else begin
                                fill <= fill_inc;
                            end
                        end else begin
                            fill <= fill_inc;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_recognizer.sv
// ---------------------------------------------------------------------------
// tb_seq_recognizer
//
// Bench for seq_recognizer. Three instances share one stimulus stream:
//   dut_a  OVERLAP=1, CW=8
//   dut_b  OVERLAP=0, CW=8
//   dut_c  OVERLAP=1, CW=2 (reaches counter saturation)
// The stimulus pushes the hand-computed z triple {c,b,a} for each ordinary
// cycle into a queue. A monitor pops that queue on the falling edge and
// compares it with the z outputs. Counts and armed are checked directly
// between cycles.
// ---------------------------------------------------------------------------
module tb_seq_recognizer;

    localparam logic [1:0] SA = 2'b01;
    localparam logic [1:0] SB = 2'b10;
    localparam logic [7:0] PAT_ABBA = 8'h69;
    localparam logic [7:0] PAT_AAAA = 8'h55;

    logic       clock = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] pattern;
    logic       valid;
    logic [1:0] x;

    logic       z_a, z_b, z_c;
    logic [7:0] count_a, count_b;
    logic [1:0] count_c;
    logic       armed_a, armed_b, armed_c;

    int tests    = 0;
    int failures = 0;
    logic [2:0] exp_q[$];

    always #5 clock = ~clock;

    seq_recognizer #(.W(2), .L(4), .OVERLAP(1), .CW(8)) dut_a (
        .clock(clock), .reset(reset), .load(load), .pattern(pattern),
        .valid(valid), .x(x), .z(z_a), .count(count_a), .armed(armed_a)
    );

    seq_recognizer #(.W(2), .L(4), .OVERLAP(0), .CW(8)) dut_b (
        .clock(clock), .reset(reset), .load(load), .pattern(pattern),
        .valid(valid), .x(x), .z(z_b), .count(count_b), .armed(armed_b)
    );

    seq_recognizer #(.W(2), .L(4), .OVERLAP(1), .CW(2)) dut_c (
        .clock(clock), .reset(reset), .load(load), .pattern(pattern),
        .valid(valid), .x(x), .z(z_c), .count(count_c), .armed(armed_c)
    );

    // Monitor: on each ordinary cycle (no reset and no load), compare the
    // three z outputs with the triple the stimulus pushed for that cycle.
    always @(negedge clock) begin : monitor
        logic [2:0] e;
        if (!reset && !load && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({z_c, z_b, z_a} !== e) begin
                failures++;
                $display("[TB] FAIL z_match at %0t: got {c,b,a}=%b expected %b",
                         $time, {z_c, z_b, z_a}, e);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected z triple when the
    // cycle is neither a reset nor a load.
    task automatic applyStimulus(input logic r, input logic ld, input logic [7:0] p,
                                 input logic v, input logic [1:0] s, input logic [2:0] ez);
        reset   = r;
        load    = ld;
        pattern = p;
        valid   = v;
        x       = s;
        if (!r && !ld) exp_q.push_back(ez);
        @(posedge clock);
        #1;
        reset = 1'b0;
        load  = 1'b0;
        valid = 1'b0;
    endtask

    // Check the registered outputs of all three instances.
    task automatic checkOutput(input string name, input logic [7:0] ea, input logic [7:0] eb,
                               input logic [1:0] ec, input logic [2:0] earmed);
        tests++;
        if (count_a !== ea || count_b !== eb || count_c !== ec ||
            {armed_c, armed_b, armed_a} !== earmed) begin
            failures++;
            $display("[TB] FAIL %s: got counts a=%0d b=%0d c=%0d armed=%b expected a=%0d b=%0d c=%0d armed=%b",
                     name, count_a, count_b, count_c, {armed_c, armed_b, armed_a},
                     ea, eb, ec, earmed);
        end
    endtask

    initial begin
        logic [1:0] seq_abba [7];
        seq_abba = '{SA, SB, SB, SA, SB, SB, SA};

        reset = 1'b1; load = 1'b0; pattern = '0; valid = 1'b0; x = '0;
        applyStimulus(1, 0, 8'h00, 0, SA, 3'b000);
        applyStimulus(1, 0, 8'h00, 0, SA, 3'b000);
        checkOutput("reset", 0, 0, 0, 3'b000);

        // A stream with no load behind it: the FSM stays in IDLE.
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 8'h00, 1, seq_abba[i], 3'b000);
        checkOutput("no_load", 0, 0, 0, 3'b000);

        // abba over the stream a b b a b b a.
        applyStimulus(0, 1, PAT_ABBA, 0, SA, 3'b000);
        checkOutput("load_abba", 0, 0, 0, 3'b111);
        for (int i = 0; i < 7; i++)
            applyStimulus(0, 0, 8'h00, 1, seq_abba[i],
                          (i == 3) ? 3'b111 : (i == 6) ? 3'b101 : 3'b000);
        checkOutput("abba_stream", 2, 1, 2, 3'b111);

        // aaaa over eight a's. dut_b matches on symbols 4 and 8, and
        // dut_c saturates at 3.
        applyStimulus(0, 1, PAT_AAAA, 0, SA, 3'b000);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 0, 8'h00, 1, SA,
                          {i >= 4, (i == 4) || (i == 8), i >= 4});
            checkOutput($sformatf("aaaa_sym%0d", i),
                        8'((i >= 4) ? i - 3 : 0),
                        8'((i >= 4 ? 1 : 0) + (i >= 8 ? 1 : 0)),
                        2'((i >= 6) ? 3 : (i >= 4) ? i - 3 : 0),
                        3'b111);
        end

        // abba with idle gaps between the symbols.
        applyStimulus(0, 1, PAT_ABBA, 0, SA, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SA, 3'b000);
        applyStimulus(0, 0, 8'h00, 0, SA, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SB, 3'b000);
        applyStimulus(0, 0, 8'h00, 0, SB, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SB, 3'b000);
        applyStimulus(0, 0, 8'h00, 0, SA, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SA, 3'b111);
        checkOutput("abba_gaps", 1, 1, 1, 3'b111);

        // A load together with the completing symbol drops that symbol.
        applyStimulus(0, 1, PAT_ABBA, 0, SA, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SA, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SB, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SB, 3'b000);
        applyStimulus(0, 1, PAT_ABBA, 1, SA, 3'b000);
        checkOutput("load_discard", 0, 0, 0, 3'b111);
        applyStimulus(0, 0, 8'h00, 1, SA, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SB, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SB, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SA, 3'b111);
        checkOutput("after_reload", 1, 1, 1, 3'b111);

        // Reset partway through a pattern returns the FSM to IDLE.
        applyStimulus(0, 1, PAT_ABBA, 0, SA, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SA, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SB, 3'b000);
        applyStimulus(1, 0, 8'h00, 1, SB, 3'b000);
        checkOutput("reset_mid", 0, 0, 0, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SB, 3'b000);
        applyStimulus(0, 0, 8'h00, 1, SA, 3'b000);
        checkOutput("idle_after_reset", 0, 0, 0, 3'b000);

        @(negedge clock);
        tests++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
